// File: rtl/imm_encoder.sv
// RV32I immediate packer: inverse of the immediate extractor, 2-stage valid/ready pipeline.
// Optional saturating range-error counter enabled by defining IMM_ENC_ERR_CNT_EN.
package imm_enc_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;
endpackage

module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  imm_src_t             i_imm_src,
  input  logic [31:0]          i_imm,
  input  logic [31:0]          i_base,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_instr,
  output logic                 o_range_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  // True when v sign-extends from its low n bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (n - 1));
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

  logic        s1_valid_q, s1_valid_d;
  imm_src_t    s1_src_q, s1_src_d;
  logic [20:0] s1_imm_q, s1_imm_d;
  logic [31:0] s1_base_q, s1_base_d;
  logic        s1_err_q, s1_err_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;

  logic        s1_adv, s2_adv, accept, in_err;
  logic [31:0] pack_w;

  always_comb begin
    s2_adv = !s2_valid_q || i_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign o_ready = s1_adv;
  assign accept  = i_valid && s1_adv;

  always_comb begin
    in_err = 1'b1;
    case (i_imm_src)
      IMM_I, IMM_S: in_err = !fits_signed(i_imm, 12);
      IMM_B:        in_err = !fits_signed(i_imm, 13) || i_imm[0];
      IMM_U:        in_err = !fits_signed(i_imm, 20);
      IMM_J:        in_err = !fits_signed(i_imm, 21) || i_imm[0];
      default:      in_err = 1'b1;
    endcase
  end

  // Unknown formats fall through with the base word untouched.
  always_comb begin
    pack_w = s1_base_q;
    case (s1_src_q)
      IMM_I: pack_w[31:20] = s1_imm_q[11:0];
      IMM_S: begin
        pack_w[31:25] = s1_imm_q[11:5];
        pack_w[11:7]  = s1_imm_q[4:0];
      end
      IMM_B: begin
        pack_w[31]    = s1_imm_q[12];
        pack_w[7]     = s1_imm_q[11];
        pack_w[30:25] = s1_imm_q[10:5];
        pack_w[11:8]  = s1_imm_q[4:1];
      end
      IMM_U: pack_w[31:12] = s1_imm_q[19:0];
      IMM_J: begin
        pack_w[31]    = s1_imm_q[20];
        pack_w[19:12] = s1_imm_q[19:12];
        pack_w[20]    = s1_imm_q[11];
        pack_w[30:21] = s1_imm_q[10:1];
      end
      default: pack_w = s1_base_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src_d   = s1_src_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s1_err_d   = s1_err_q;
    if (s1_adv) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_src_d  = i_imm_src;
        s1_imm_d  = i_imm[20:0];
        s1_base_d = i_base;
        s1_err_d  = in_err;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = pack_w;
        s2_err_d   = s1_err_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= IMM_I;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_instr     = s2_instr_q;
  assign o_range_err = s2_err_q;

`ifdef IMM_ENC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts at acceptance so a stalled output never double-counts.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && in_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors plus a queue-based reference model.
module tb_imm_encoder;
  import imm_enc_pkg::*;

`ifdef IMM_ENC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, o_ready, o_valid, i_ready, o_range_err;
  imm_src_t    i_imm_src;
  logic [31:0] i_imm, i_base, o_instr;
  logic [15:0] o_err_cnt;

  always #5 i_clk = ~i_clk;

  imm_encoder #(.ERR_CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_imm_src(i_imm_src), .i_imm(i_imm), .i_base(i_base),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
    .o_range_err(o_range_err), .o_err_cnt(o_err_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    imm_src_t    src;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int acc_cnt = 0, out_cnt = 0, cnt_model = 0;
  bit mon_on = 1'b0, rnd_ready = 1'b0;
  bit have_hold = 1'b0;
  logic [31:0] hold_instr;
  logic        hold_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packing: range from signed arithmetic, fields by shift/mask.
  function automatic logic [32:0] model(input imm_src_t s, input logic [31:0] imm,
                                        input logic [31:0] base);
    longint v;
    logic [31:0] mask, field;
    logic err;
    v = longint'($signed(imm));
    mask = 32'h0; field = 32'h0; err = 1'b1;
    case (s)
      IMM_I: begin
        mask = 32'hFFF0_0000; field = imm << 20;
        err = !(v >= -2048 && v <= 2047);
      end
      IMM_S: begin
        mask = 32'hFE00_0F80;
        field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        err = !(v >= -2048 && v <= 2047);
      end
      IMM_B: begin
        mask = 32'hFE00_0F80;
        field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7) |
                (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
        err = !(v >= -4096 && v <= 4095) || (imm % 2 != 0);
      end
      IMM_U: begin
        mask = 32'hFFFF_F000; field = imm << 12;
        err = !(v >= -524288 && v <= 524287);
      end
      IMM_J: begin
        mask = 32'hFFFF_F000;
        field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 12) & 32'hFF) << 12) |
                (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21);
        err = !(v >= -1048576 && v <= 1048575) || (imm % 2 != 0);
      end
      default: begin
        mask = 32'h0; field = 32'h0; err = 1'b1;
      end
    endcase
    return {err, (base & ~mask) | (field & mask)};
  endfunction

  // Standard RV32I immediate extraction, used for the round-trip property.
  function automatic logic [31:0] extract(input logic [31:0] x, input imm_src_t s);
    case (s)
      IMM_I:   return {{20{x[31]}}, x[31:20]};
      IMM_S:   return {{20{x[31]}}, x[31:25], x[11:7]};
      IMM_B:   return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      IMM_U:   return {{12{x[31]}}, x[31:12]};
      IMM_J:   return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Compare process: sampled on negedge, predicts what the next posedge does.
  always @(negedge i_clk) begin
    exp_t e;
    logic [32:0] m;
    if (mon_on) begin
      chk("o_ready", 32'(o_ready), 32'((q.size() < 2) || i_ready));
      chk("o_err_cnt", 32'(o_err_cnt), 32'(cnt_model));
      if (have_hold) begin
        chk("stall_instr_stable", o_instr, hold_instr);
        chk("stall_err_stable", 32'(o_range_err), 32'(hold_err));
      end
      if (i_rst) begin
        q.delete();
        cnt_model = 0;
        have_hold = 1'b0;
      end else begin
        have_hold  = o_valid && !i_ready;
        hold_instr = o_instr;
        hold_err   = o_range_err;
        if (o_valid && i_ready) begin
          chk("no_extra_output", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("o_instr", o_instr, e.instr);
            chk("o_range_err", 32'(o_range_err), 32'(e.err));
            if (!e.err) chk("round_trip", extract(o_instr, e.src), e.imm);
            out_cnt++;
          end
        end
        if (i_valid && o_ready) begin
          m = model(i_imm_src, i_imm, i_base);
          e.instr = m[31:0];
          e.err   = m[32];
          e.imm   = i_imm;
          e.src   = i_imm_src;
          q.push_back(e);
          acc_cnt++;
          if (CNT_EN && m[32] && cnt_model != 65535) cnt_model++;
        end
      end
    end
  end

  task automatic send(input imm_src_t s, input logic [31:0] imm, input logic [31:0] base);
    i_valid = 1'b1; i_imm_src = s; i_imm = imm; i_base = base;
    for (int n = 0; n < 50; n++) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        return;
      end
      @(posedge i_clk); #1;
      if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
    end
    checks++; failures++;
    $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    i_valid = 1'b0;
  endtask

  task automatic directed(input string name, input imm_src_t s, input logic [31:0] imm,
                          input logic [31:0] base, input logic [31:0] exp_instr,
                          input logic exp_err);
    bit seen;
    seen = 1'b0;
    send(s, imm, base);
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_instr"}, o_instr, exp_instr);
    chk({name, "_err"}, 32'(o_range_err), 32'(exp_err));
    @(posedge i_clk); #1;
  endtask

  logic [31:0] tbl [20] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FF, 32'h800, 32'hFFFF_F800,
                            32'hFFFF_F7FF, 32'hFFE, 32'hFFF, 32'h1000, 32'hFFFF_F000,
                            32'h7FFFF, 32'h80000, 32'hFFF8_0000, 32'hFFFE, 32'hFFFFE,
                            32'h100000, 32'hFFF0_0000, 32'hFFEF_FFFE, 32'h1234_5678};

  initial begin
    int acc0, out0;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_imm_src = IMM_I; i_imm = 32'h0; i_base = 32'h0;
    @(posedge i_clk); @(negedge i_clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_instr", o_instr, 32'h0);
    chk("rst_o_range_err", 32'(o_range_err), 32'd0);
    chk("rst_o_err_cnt", 32'(o_err_cnt), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    mon_on = 1'b1;

    send(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013);
    @(negedge i_clk);
    chk("lat_cycle1_valid", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    chk("lat_cycle2_valid", 32'(o_valid), 32'd1);
    chk("lat_instr", o_instr, 32'hFFF0_0013);
    chk("lat_err", 32'(o_range_err), 32'd0);
    @(posedge i_clk); #1;

    chk("cnt_before_u", 32'(o_err_cnt), 32'd0);
    directed("u_over", IMM_U, 32'h0008_0000, 32'h0000_0037, 32'h8000_0037, 1'b1);
    chk("cnt_after_u", 32'(o_err_cnt), CNT_EN ? 32'd1 : 32'd0);
    directed("b_ok", IMM_B, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
    directed("b_odd", IMM_B, 32'h0000_0FFF, 32'h0000_0063, 32'h7E00_0FE3, 1'b1);
    directed("j_neg2", IMM_J, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0);
    directed("i_over", IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    directed("s_min", IMM_S, 32'hFFFF_F800, 32'h0000_0023, 32'h8000_0023, 1'b0);
    directed("bad_src", imm_src_t'(3'd7), 32'h0000_0005, 32'h1234_5678, 32'h1234_5678, 1'b1);
    chk("cnt_after_dir", 32'(o_err_cnt), CNT_EN ? 32'd4 : 32'd0);

    // Three back-to-back requests against a stalled sink.
    i_ready = 1'b0;
    acc0 = acc_cnt; out0 = out_cnt;
    fork
      begin
        for (int k = 0; k < 3; k++) send(IMM_I, 32'(k + 1), 32'h0000_0013);
      end
      begin
        repeat (6) @(negedge i_clk);
        chk("stall_accepted", 32'(acc_cnt - acc0), 32'd2);
        chk("stall_o_ready", 32'(o_ready), 32'd0);
        chk("stall_o_valid", 32'(o_valid), 32'd1);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
      end
    join
    repeat (6) @(negedge i_clk);
    chk("stall_drained", 32'(out_cnt - out0), 32'd3);
    chk("stall_queue_empty", 32'(q.size()), 32'd0);
    @(posedge i_clk); #1;

    // Reset with two entries in flight.
    i_ready = 1'b0;
    send(IMM_J, 32'h0000_0010, 32'h0000_006F);
    send(IMM_U, 32'h0008_0000, 32'h0000_0037);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o_err_cnt", 32'(o_err_cnt), 32'd0);
    chk("midrst_o_ready", 32'(o_ready), 32'd1);
    out0 = out_cnt;
    i_ready = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("midrst_nothing_emitted", 32'(out_cnt - out0), 32'd0);
    @(posedge i_clk); #1;

    // Boundary sweep with random formats, bases and sink backpressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 60; k++)
      send(imm_src_t'(3'($urandom_range(0, 5))), tbl[$urandom_range(0, 19)], $urandom());
    rnd_ready = 1'b0;
    i_ready = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("sweep_queue_empty", 32'(q.size()), 32'd0);
    chk("sweep_in_eq_out", 32'(out_cnt), 32'(acc_cnt - 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
